// File: rtl/lfsr_encrypt_stage_pkg.sv
// rtl/lfsr_encrypt_stage_pkg.sv - shared constants, FSM state type and helpers for the LFSR encrypt stage
// Purpose: tap table, preamble character, preamble length limits, FSM state enum, clamp helper.
// Ports: none (package).
package enc_pkg;

  localparam logic [5:0] LFSR_PTRN [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  localparam logic [7:0] PREAMBLE_CHAR = 8'h5F;

  localparam logic [3:0] PRE_MIN = 4'd7;
  localparam logic [3:0] PRE_MAX = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Out-of-range preamble lengths are pulled to the nearest legal value.
  function automatic logic [3:0] clamp_pre(input logic [3:0] len);
    if (len < PRE_MIN)      return PRE_MIN;
    else if (len > PRE_MAX) return PRE_MAX;
    else                    return len;
  endfunction

endpackage

// File: rtl/lfsr_encrypt_stage_lfsr6b.sv
// rtl/lfsr_encrypt_stage_lfsr6b.sv - 6-bit Fibonacci LFSR with load and enable
// Purpose: keystream generator; init loads seed, en shifts in the tap parity.
// Ports:
//   clk   in  1  clock, rising edge
//   init  in  1  load seed (priority over en)
//   en    in  1  advance one step
//   seed  in  6  load value
//   taps  in  6  feedback tap mask
//   lfsr  out 6  current state
module lfsr6b (
  input  logic       clk,
  input  logic       init,
  input  logic       en,
  input  logic [5:0] seed,
  input  logic [5:0] taps,
  output logic [5:0] lfsr
);

  // No reset: the state is always loaded through init before it is consumed.
  always_ff @(posedge clk) begin
    if (init) begin
      lfsr <= seed;
    end else if (en) begin
      lfsr <= {lfsr[4:0], ^(lfsr & taps)};
    end
  end

endmodule

// File: rtl/lfsr_encrypt_stage.sv
// rtl/lfsr_encrypt_stage.sv - preamble + plaintext encryptor writing a 64-byte LFSR-XORed image
// Purpose: reads plaintext from dat_mem, prepends underscore preamble, XORs with a 6-bit LFSR
//          stream and writes the image to ENC_BASE.. for the downstream decrypter.
// Option: define ENC_PARITY_EN to replace bit 7 of each written byte with even parity of bits 6:0.
// Ports:
//   clk      in  1  clock, rising edge
//   init_n   in  1  synchronous active-low reset
//   start    in  1  run request (accepted in IDLE/DONE)
//   tap_sel  in  3  tap pattern index 0..5
//   seed     in  6  LFSR start state, nonzero
//   pre_len  in  4  preamble length (clamped to 7..12)
//   raddr    out 8  memory read address
//   data_out in  8  memory read data (combinational)
//   wr_en    out 1  memory write strobe
//   waddr    out 8  memory write address
//   data_in  out 8  memory write data
//   busy     out 1  LOAD or WRITE
//   done     out 1  DONE
//   err      out 1  one-cycle pulse on rejected start
module lfsr_encrypt_stage
  import enc_pkg::*;
#(
  parameter int MSG_BASE = 0,
  parameter int ENC_BASE = 64,
  parameter int IMG_LEN  = 64
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  input  logic [2:0] tap_sel,
  input  logic [5:0] seed,
  input  logic [3:0] pre_len,
  output logic [7:0] raddr,
  input  logic [7:0] data_out,
  output logic       wr_en,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     state;
  logic [5:0] seed_q;
  logic [2:0] tap_sel_q;
  logic [3:0] pre_q;
  logic [7:0] k;
  logic       err_q;
  logic [5:0] lfsr;

  logic       legal;
  logic       in_pre;
  logic [7:0] pre8;
  logic [7:0] plain;
  logic [7:0] enc;

  assign legal = (seed != 6'd0) && (tap_sel <= 3'd5);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state     <= S_IDLE;
      seed_q    <= 6'd0;
      tap_sel_q <= 3'd0;
      pre_q     <= PRE_MIN;
      k         <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (legal) begin
              seed_q    <= seed;
              tap_sel_q <= tap_sel;
              pre_q     <= clamp_pre(pre_len);
              k         <= 8'd0;
              state     <= S_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: state <= S_WRITE;
        S_WRITE: begin
          k <= k + 8'd1;
          if (k == 8'(IMG_LEN - 1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The LFSR is loaded during LOAD so the seed is present for the first WRITE byte.
  lfsr6b u_lfsr (
    .clk  (clk),
    .init (state == S_LOAD),
    .en   (state == S_WRITE),
    .seed (seed_q),
    .taps (LFSR_PTRN[tap_sel_q]),
    .lfsr (lfsr)
  );

  assign pre8   = {4'd0, pre_q};
  assign in_pre = (k < pre8);
  assign plain  = in_pre ? PREAMBLE_CHAR : data_out;
  assign enc    = plain ^ {2'b00, lfsr};

  always_comb begin
    raddr   = 8'(MSG_BASE);
    waddr   = 8'(ENC_BASE);
    wr_en   = 1'b0;
    data_in = 8'd0;
    if (state == S_WRITE) begin
      wr_en = 1'b1;
      waddr = 8'(ENC_BASE) + k;
      if (!in_pre) raddr = 8'(MSG_BASE) + k - pre8;
`ifdef ENC_PARITY_EN
      data_in = {^enc[6:0], enc[6:0]};
`else
      data_in = enc;
`endif
    end
  end

  assign busy = (state == S_LOAD) || (state == S_WRITE);
  assign done = (state == S_DONE);
  assign err  = err_q;

endmodule
